// File: rtl/bcd_seg_scan.sv
// Scanned 7-digit BCD display driver: frame-synchronous snapshot, leading-zero
// blanking, decimal point, registered anode/segment outputs with anti-ghost gap.
module bcd_seg_scan #(
   parameter int   SCAN_DIV   = 12500,
   parameter int   GAP_CYCLES = 2,
   parameter logic AN_ACT     = 1'b1,
   parameter logic SEG_ACT    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] d4,
   input  logic [3:0] d5,
   input  logic [3:0] d6,
   input  logic       update,
   input  logic       blank_en,
   input  logic       dp_en,
   input  logic [2:0] dp_pos,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_done
);

   localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
   localparam logic [TW-1:0] GAP_T     = TW'(GAP_CYCLES);

   logic [TW-1:0]   tick_cnt;
   logic [2:0]      idx;
   logic            pending;
   logic [6:0][3:0] staging;
   logic [6:0][3:0] shadow;
   logic [6:0][3:0] din;
   logic            wrap;
   logic            boundary;
   logic [6:0]      blank;
   logic            upper_zero;
   logic [3:0]      cur_code;
   logic            cur_blank;
   logic [7:0]      an_nxt;
   logic [6:0]      seg_nxt;
   logic            dp_nxt;

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   assign din      = {d6, d5, d4, d3, d2, d1, d0};
   assign wrap     = (tick_cnt == TICK_LAST);
   assign boundary = wrap && (idx == 3'd6);

   // A digit blanks only if it and everything above it is zero and it sits left of the dp.
   always_comb begin
      upper_zero = 1'b1;
      blank      = '0;
      for (int i = 6; i >= 1; i--) begin
         upper_zero = upper_zero && (shadow[i] == 4'd0);
         blank[i]   = blank_en && upper_zero && (!dp_en || (3'(i) > dp_pos));
      end
   end

   always_comb begin
      cur_code  = 4'd0;
      cur_blank = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (idx == 3'(i)) begin
            cur_code  = shadow[i];
            cur_blank = blank[i];
         end
      end
      an_nxt = '0;
      if (tick_cnt >= GAP_T) an_nxt[idx] = 1'b1;
      seg_nxt = cur_blank ? 7'h00 : seg_decode(cur_code);
      dp_nxt  = dp_en && (dp_pos == idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt   <= '0;
         idx        <= 3'd0;
         pending    <= 1'b0;
         staging    <= '0;
         shadow     <= '0;
         an         <= {8{~AN_ACT}};
         seg        <= {7{~SEG_ACT}};
         dp         <= ~SEG_ACT;
         frame_done <= 1'b0;
      end else begin
         if (wrap) begin
            tick_cnt <= '0;
            idx      <= (idx == 3'd6) ? 3'd0 : idx + 3'd1;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end

         if (update) staging <= din;
         // A request landing on the boundary itself bypasses staging.
         if (boundary) begin
            if (update)       shadow <= din;
            else if (pending) shadow <= staging;
            pending <= 1'b0;
         end else if (update) begin
            pending <= 1'b1;
         end

         an         <= an_nxt ^ {8{~AN_ACT}};
         seg        <= seg_nxt ^ {7{~SEG_ACT}};
         dp         <= dp_nxt ^ ~SEG_ACT;
         frame_done <= boundary;
      end
   end

endmodule
